link_exchange_ctrl: RTL and testbench
=====================================

Name: link_exchange_ctrl

Overview:
- Per-frame scheduler for the two-board game link. Once per video frame it sends the local player location to the opponent board through the SPI transmitter and collects the opponent's record from the SPI receiver.
- Enforces a receive timeout and tracks link health.
- Presents one aligned (player, opponent) pair per frame to the game-logic/render pipeline, replacing the ad-hoc pairing logic.

Parameters:
- LOC_WIDTH, 20, width of the local location word (x,y packed).
- DATA_WIDTH, 32, width of the opponent data record.
- TIMEOUT_CYCLES, 200000, clk_pixel_in cycles to wait for opponent data after TX completes.
- MISS_LIMIT, 4, consecutive missed exchanges before link_up_out drops.
- LOCK_COUNT, 2, consecutive good exchanges before link_up_out rises.

Ports:
- clk_pixel_in  input  1  pixel clock; the only clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- frame_start_in  input  1  single-cycle pulse at start of vertical blank.
- location_in  input  LOC_WIDTH  local player location.
- location_in_valid  input  1  location_in valid this cycle.
- tx_ready_in  input  1  SPI transmitter idle, can accept a word.
- tx_start_out  output  1  single-cycle pulse; transmitter latches tx_data_out.
- tx_data_out  output  LOC_WIDTH  word to transmit.
- tx_done_in  input  1  single-cycle pulse when the transmission finishes.
- rx_data_in  input  DATA_WIDTH  received opponent record.
- rx_valid_in  input  1  single-cycle pulse; rx_data_in valid.
- player_location_out  output  LOC_WIDTH  location sent this frame.
- opponent_data_out  output  DATA_WIDTH  opponent record for this frame.
- data_out_valid  output  1  single-cycle pulse; both data outputs updated.
- stale_out  output  1  opponent_data_out is a repeat of the last good record.
- link_up_out  output  1  link healthy.

Behaviour:
- Reset (rst_n_in low, asynchronous): state IDLE, all outputs 0, counters 0, rx_pending 0, last-good register 0.
- FSM states: IDLE, WAIT_LOC, SEND, WAIT_TXDONE, WAIT_RX, DELIVER.
- IDLE: frame_start_in -> WAIT_LOC.
- WAIT_LOC: on location_in_valid, latch location_in into loc_q -> SEND.
- SEND: while tx_ready_in=1, assert tx_start_out for exactly one cycle with tx_data_out=loc_q -> WAIT_TXDONE. tx_data_out holds loc_q until the next SEND.
- WAIT_TXDONE: on tx_done_in -> WAIT_RX; clear the timeout counter.
- WAIT_RX:
  - If rx_pending or rx_valid_in: latch the record as good -> DELIVER.
  - Timeout counter increments each cycle. At TIMEOUT_CYCLES-1 -> DELIVER as a miss.
- rx capture: rx_valid_in in any state other than IDLE sets rx_pending and latches rx_data_in into rx_q; a later pulse overwrites rx_q. This covers the opponent answering before our TX completes. rx_valid_in in IDLE is dropped.
- DELIVER, one cycle, then -> IDLE:
  - data_out_valid=1; player_location_out=loc_q.
  - Good exchange: opponent_data_out=rx_q; last-good register <= rx_q; stale_out=0; miss counter <= 0; good counter increments, saturating at LOCK_COUNT.
  - Miss: opponent_data_out=last-good register; stale_out=1; good counter <= 0; miss counter increments, saturating at MISS_LIMIT.
  - rx_pending is cleared.
- Overrun: frame_start_in in any state other than IDLE or DELIVER:
  - Abort the exchange and count a miss.
  - No data_out_valid this frame.
  - rx_pending is retained.
  - Go directly to WAIT_LOC.
- link_up_out: set when the good counter reaches LOCK_COUNT; cleared when the miss counter reaches MISS_LIMIT; registered, so it updates the cycle after DELIVER.
- Outputs hold their values between DELIVER pulses.
- Timeout counter width: clog2(TIMEOUT_CYCLES)+1. The counter never wraps.

Optional Feature:
- Macro LINK_STATS_EN.
- When defined, two extra outputs are present:
  - good_count_out[15:0]: total good exchanges.
  - miss_count_out[15:0]: total misses, including overruns.
  - Both saturate at 16'hFFFF and clear on reset.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Normal exchange: frame_start, location 20'h12345 valid, tx_done 10 cycles later, rx 32'hCAFEBABE 50 cycles later -> one data_out_valid pulse; outputs 20'h12345 and 32'hCAFEBABE; stale_out=0.
- Early RX: rx 32'h0000BEEF arrives before tx_done -> DELIVER the cycle after tx_done+1 with 32'h0000BEEF; no timeout.
- Timeout (TIMEOUT_CYCLES=100 in bench): no rx -> DELIVER 100 cycles after tx_done; opponent_data_out = last good value; stale_out=1.
- Link health (LOCK_COUNT=2, MISS_LIMIT=4): 2 good frames -> link_up_out=1; then 3 misses -> link_up_out stays 1; 4th miss -> link_up_out=0.
- Overrun: hold tx_ready_in=0 across a second frame_start -> no data_out_valid for the aborted frame; FSM in WAIT_LOC; miss counted.
- Reset mid-exchange: drop rst_n_in while in WAIT_RX -> all outputs 0 immediately (asynchronously); after release the FSM waits in IDLE for frame_start.

Source files
------------

// File: rtl/link_exchange_ctrl_if.sv
// Link exchange bus: frame/location inputs, SPI TX/RX handshake and the per-frame output pair.
// With LINK_STATS_EN defined the bus also carries the good/miss exchange totals.
interface link_exchange_ctrl_if #(
   parameter int LOC_WIDTH  = 20,
   parameter int DATA_WIDTH = 32
);
   logic                  frame_start_in;
   logic [LOC_WIDTH-1:0]  location_in;
   logic                  location_in_valid;
   logic                  tx_ready_in;
   logic                  tx_start_out;
   logic [LOC_WIDTH-1:0]  tx_data_out;
   logic                  tx_done_in;
   logic [DATA_WIDTH-1:0] rx_data_in;
   logic                  rx_valid_in;
   logic [LOC_WIDTH-1:0]  player_location_out;
   logic [DATA_WIDTH-1:0] opponent_data_out;
   logic                  data_out_valid;
   logic                  stale_out;
   logic                  link_up_out;
`ifdef LINK_STATS_EN
   logic [15:0]           good_count_out;
   logic [15:0]           miss_count_out;
`endif

   modport slave (
      input  frame_start_in, location_in, location_in_valid, tx_ready_in, tx_done_in,
             rx_data_in, rx_valid_in,
      output tx_start_out, tx_data_out, player_location_out, opponent_data_out,
             data_out_valid, stale_out, link_up_out
`ifdef LINK_STATS_EN
      , output good_count_out, miss_count_out
`endif
   );

   modport master (
      output frame_start_in, location_in, location_in_valid, tx_ready_in, tx_done_in,
             rx_data_in, rx_valid_in,
      input  tx_start_out, tx_data_out, player_location_out, opponent_data_out,
             data_out_valid, stale_out, link_up_out
`ifdef LINK_STATS_EN
      , input good_count_out, miss_count_out
`endif
   );
endinterface

// File: rtl/link_exchange_ctrl.sv
// Per-frame game-link scheduler: send local location, collect opponent record, deliver one aligned pair.
// Optional macro LINK_STATS_EN adds saturating good/miss totals on the bus.
module link_exchange_ctrl #(
   parameter int LOC_WIDTH      = 20,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int MISS_LIMIT     = 4,
   parameter int LOCK_COUNT     = 2
) (
   input  logic clk_pixel_in,
   input  logic rst_n_in,
   link_exchange_ctrl_if.slave lx
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GOOD_SAT = GW'(LOCK_COUNT);
   localparam logic [MW-1:0] MISS_SAT = MW'(MISS_LIMIT);

   typedef enum logic [2:0] {IDLE, WAIT_LOC, SEND, WAIT_TXDONE, WAIT_RX, DELIVER} state_t;

   state_t                state_q, state_d;
   logic [LOC_WIDTH-1:0]  loc_q, tx_data_q, player_q;
   logic [DATA_WIDTH-1:0] rx_q, last_good_q, opp_q, rx_sel;
   logic                  rx_pending_q;
   logic [TW-1:0]         tmo_q;
   logic [GW-1:0]         good_cnt_q;
   logic [MW-1:0]         miss_cnt_q;
   logic                  tx_start_q, dov_q, stale_q, link_q;
   logic                  go_good, go_miss, overrun, tx_fire, clr_tmo, busy;

   // A record arriving on the deciding cycle is taken straight from the bus.
   assign rx_sel = lx.rx_valid_in ? lx.rx_data_in : rx_q;
   assign busy   = (state_q == WAIT_LOC) || (state_q == SEND) ||
                   (state_q == WAIT_TXDONE) || (state_q == WAIT_RX);

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      go_good = 1'b0;
      go_miss = 1'b0;
      overrun = 1'b0;
      tx_fire = 1'b0;
      clr_tmo = 1'b0;
      if (busy && lx.frame_start_in) begin
         // New frame before this one delivered: abandon it and restart collection.
         overrun = 1'b1;
         state_d = WAIT_LOC;
      end else begin
         case (state_q)
            IDLE:        if (lx.frame_start_in) state_d = WAIT_LOC;
            WAIT_LOC:    if (lx.location_in_valid) state_d = SEND;
            SEND:        if (lx.tx_ready_in) begin
                            tx_fire = 1'b1;
                            state_d = WAIT_TXDONE;
                         end
            WAIT_TXDONE: if (lx.tx_done_in) begin
                            clr_tmo = 1'b1;
                            state_d = WAIT_RX;
                         end
            WAIT_RX:     if (rx_pending_q || lx.rx_valid_in) begin
                            go_good = 1'b1;
                            state_d = DELIVER;
                         end else if (tmo_q == TMO_LAST) begin
                            go_miss = 1'b1;
                            state_d = DELIVER;
                         end
            DELIVER:     state_d = IDLE;
            default:     state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         loc_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         tmo_q      <= '0;
      end else begin
         tx_start_q <= tx_fire;
         if (state_q == WAIT_LOC && state_d == SEND) loc_q <= lx.location_in;
         if (tx_fire) tx_data_q <= loc_q;
         if (clr_tmo) tmo_q <= '0;
         else if (state_q == WAIT_RX && tmo_q != {TW{1'b1}}) tmo_q <= tmo_q + 1'b1;
      end
   end

   // Early answers (before our TX completes) park here until WAIT_RX consumes them.
   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rx_q         <= '0;
         rx_pending_q <= 1'b0;
      end else if (lx.rx_valid_in && state_q != IDLE) begin
         rx_q         <= lx.rx_data_in;
         rx_pending_q <= 1'b1;
      end else if (state_q == DELIVER) begin
         rx_pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         dov_q       <= 1'b0;
         player_q    <= '0;
         opp_q       <= '0;
         last_good_q <= '0;
         stale_q     <= 1'b0;
         good_cnt_q  <= '0;
         miss_cnt_q  <= '0;
         link_q      <= 1'b0;
      end else begin
         dov_q <= go_good || go_miss;
         if (go_good || go_miss) player_q <= loc_q;
         if (go_good) begin
            opp_q       <= rx_sel;
            last_good_q <= rx_sel;
            stale_q     <= 1'b0;
            miss_cnt_q  <= '0;
            if (good_cnt_q != GOOD_SAT) good_cnt_q <= good_cnt_q + 1'b1;
         end else if (go_miss || overrun) begin
            if (go_miss) begin
               opp_q   <= last_good_q;
               stale_q <= 1'b1;
            end
            good_cnt_q <= '0;
            if (miss_cnt_q != MISS_SAT) miss_cnt_q <= miss_cnt_q + 1'b1;
         end
         // Follows the counters by one cycle, i.e. settles just after DELIVER.
         if (good_cnt_q == GOOD_SAT)      link_q <= 1'b1;
         else if (miss_cnt_q == MISS_SAT) link_q <= 1'b0;
      end
   end

`ifdef LINK_STATS_EN
   logic [15:0] stat_good_q, stat_miss_q;

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stat_good_q <= '0;
         stat_miss_q <= '0;
      end else begin
         if (go_good && stat_good_q != 16'hFFFF) stat_good_q <= stat_good_q + 16'd1;
         if ((go_miss || overrun) && stat_miss_q != 16'hFFFF) stat_miss_q <= stat_miss_q + 16'd1;
      end
   end

   assign lx.good_count_out = stat_good_q;
   assign lx.miss_count_out = stat_miss_q;
`endif

   assign lx.tx_start_out        = tx_start_q;
   assign lx.tx_data_out         = tx_data_q;
   assign lx.player_location_out = player_q;
   assign lx.opponent_data_out   = opp_q;
   assign lx.data_out_valid      = dov_q;
   assign lx.stale_out           = stale_q;
   assign lx.link_up_out         = link_q;
endmodule

// File: tb/tb_link_exchange_ctrl.sv
// Randomized bench for link_exchange_ctrl: a frame-level model queues expected deliveries,
// and an independent monitor checks each data_out_valid pulse against the queue.
module tb_link_exchange_ctrl;
   localparam int LW = 20, DW = 32, TMO = 100, LOCK = 2, MISSL = 4;
   localparam int M_NORMAL = 0, M_EARLY = 1, M_TIMEOUT = 2, M_PEND = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   link_exchange_ctrl_if #(.LOC_WIDTH(LW), .DATA_WIDTH(DW)) lx ();

   link_exchange_ctrl #(
      .LOC_WIDTH(LW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO),
      .MISS_LIMIT(MISSL), .LOCK_COUNT(LOCK)
   ) dut (
      .clk_pixel_in(clk),
      .rst_n_in(rst_n),
      .lx(lx)
   );

   typedef struct {
      logic [LW-1:0] loc;
      logic [DW-1:0] data;
      logic          stale;
      logic          link;
   } exp_t;

   exp_t sb[$];
   int tests = 0, fails = 0;

   // Frame-level reference: outcome history decides data, staleness and link health.
   logic [DW-1:0] m_last = '0;
   int m_good_run = 0, m_miss_run = 0, m_gtot = 0, m_mtot = 0;
   logic m_link = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_good(input logic [LW-1:0] loc, input logic [DW-1:0] d);
      exp_t e;
      m_last = d;
      m_miss_run = 0;
      m_good_run = (m_good_run < LOCK) ? m_good_run + 1 : LOCK;
      if (m_good_run == LOCK) m_link = 1'b1;
      m_gtot++;
      e.loc = loc; e.data = d; e.stale = 1'b0; e.link = m_link;
      sb.push_back(e);
   endfunction

   function automatic void model_miss(input logic [LW-1:0] loc, input bit deliver);
      exp_t e;
      m_good_run = 0;
      m_miss_run = (m_miss_run < MISSL) ? m_miss_run + 1 : MISSL;
      if (m_miss_run == MISSL) m_link = 1'b0;
      m_mtot++;
      e.loc = loc; e.data = m_last; e.stale = 1'b1; e.link = m_link;
      if (deliver) sb.push_back(e);
   endfunction

   // Monitor: pops on every delivery; link health is checked on the following cycle.
   exp_t mon_e;
   logic link_chk = 1'b0, link_exp = 1'b0;
   int dov_cnt = 0, txs_cnt = 0;

   always @(negedge clk) begin
      if (link_chk) begin
         chk("link_up_out", lx.link_up_out, link_exp);
         link_chk = 1'b0;
      end
      if (rst_n && lx.data_out_valid) begin
         dov_cnt++;
         if (sb.size() == 0) chk("spurious data_out_valid", lx.data_out_valid, 1'b0);
         else begin
            mon_e = sb.pop_front();
            chk("player_location_out", lx.player_location_out, mon_e.loc);
            chk("opponent_data_out", lx.opponent_data_out, mon_e.data);
            chk("stale_out", lx.stale_out, mon_e.stale);
            link_exp = mon_e.link;
            link_chk = 1'b1;
         end
      end
   end

   always @(negedge clk) if (lx.tx_start_out) txs_cnt++;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_frame();
      lx.frame_start_in = 1'b1;
      tick();
      lx.frame_start_in = 1'b0;
   endtask

   task automatic give_loc(input logic [LW-1:0] loc);
      repeat ($urandom_range(0, 3)) tick();
      lx.location_in = loc;
      lx.location_in_valid = 1'b1;
      tick();
      lx.location_in_valid = 1'b0;
      lx.location_in = LW'($urandom);
   endtask

   task automatic pulse_rx(input logic [DW-1:0] d);
      lx.rx_data_in = d;
      lx.rx_valid_in = 1'b1;
      tick();
      lx.rx_valid_in = 1'b0;
      lx.rx_data_in = DW'($urandom);
   endtask

   task automatic wait_tx_start(input logic [LW-1:0] loc);
      int n = 0;
      bit seen = 0;
      while (n < 50 && !seen) begin
         @(negedge clk);
         if (lx.tx_start_out) seen = 1;
         else begin @(posedge clk); #1; n++; end
      end
      chk("tx_start_out seen", seen, 1'b1);
      if (seen) chk("tx_data_out", lx.tx_data_out, loc);
      @(posedge clk); #1;
   endtask

   task automatic pulse_tx_done(input int dly);
      repeat (dly) tick();
      lx.tx_done_in = 1'b1;
      tick();
      lx.tx_done_in = 1'b0;
   endtask

   // Counts cycles from the edge that sampled tx_done (or rx) to the delivery pulse.
   task automatic wait_deliver(input int exp_m);
      int m = 0;
      bit got = 0;
      while (m <= TMO + 20 && !got) begin
         @(negedge clk);
         if (lx.data_out_valid) got = 1;
         else begin @(posedge clk); #1; m++; end
      end
      chk("delivery latency", m, exp_m);
      @(posedge clk); #1;
      tick();
   endtask

   task automatic run_body(input int mode, input logic [LW-1:0] loc, input logic [DW-1:0] rxd,
                           input int dtx, input int drx);
      lx.tx_ready_in = 1'b1;
      give_loc(loc);
      wait_tx_start(loc);
      if (mode == M_EARLY) begin
         pulse_rx(DW'($urandom));
         pulse_rx(rxd);
      end
      pulse_tx_done(dtx);
      case (mode)
         M_NORMAL: begin
            repeat (drx - 1) tick();
            model_good(loc, rxd);
            pulse_rx(rxd);
            wait_deliver(0);
         end
         M_EARLY, M_PEND: begin
            model_good(loc, rxd);
            wait_deliver(1);
         end
         default: begin
            model_miss(loc, 1'b1);
            wait_deliver(TMO);
         end
      endcase
   endtask

   task automatic frame(input int mode, input logic [LW-1:0] loc, input logic [DW-1:0] rxd,
                        input int dtx, input int drx);
      start_frame();
      run_body(mode, loc, rxd, dtx, drx);
   endtask

   // Overrun with a record already received: that record must survive into the next frame.
   task automatic overrun_frame(input logic [LW-1:0] loc_a, input logic [LW-1:0] loc_b,
                                input logic [DW-1:0] keep);
      int d0, t0;
      start_frame();
      lx.tx_ready_in = 1'b0;
      give_loc(loc_a);
      pulse_rx(keep);
      d0 = dov_cnt; t0 = txs_cnt;
      repeat (4) tick();
      start_frame();
      model_miss(loc_a, 1'b0);
      tick(); tick();
      chk("no tx_start while not ready", txs_cnt, t0);
      chk("no delivery for aborted frame", dov_cnt, d0);
      chk("link_up_out after overrun", lx.link_up_out, m_link);
      run_body(M_PEND, loc_b, keep, 2, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " tx_start_out"}, lx.tx_start_out, 1'b0);
      chk({tag, " tx_data_out"}, lx.tx_data_out, '0);
      chk({tag, " player_location_out"}, lx.player_location_out, '0);
      chk({tag, " opponent_data_out"}, lx.opponent_data_out, '0);
      chk({tag, " data_out_valid"}, lx.data_out_valid, 1'b0);
      chk({tag, " stale_out"}, lx.stale_out, 1'b0);
      chk({tag, " link_up_out"}, lx.link_up_out, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      lx.frame_start_in = 1'b0; lx.location_in = '0; lx.location_in_valid = 1'b0;
      lx.tx_ready_in = 1'b1; lx.tx_done_in = 1'b0; lx.rx_data_in = '0; lx.rx_valid_in = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (3) tick();

      // Directed: normal, early, 4 timeouts (link rises then drops), overrun.
      frame(M_NORMAL, 20'h12345, 32'hCAFEBABE, 10, 50);
      frame(M_EARLY, 20'h0ABCD, 32'h0000BEEF, 6, 0);
      repeat (4) frame(M_TIMEOUT, LW'($urandom), '0, 3, 0);
      overrun_frame(20'h11111, 20'h22222, 32'h5A5A1234);

      for (int i = 0; i < 24; i++) begin
         int md;
         md = $urandom_range(0, 3);
         if (md == 3) overrun_frame(LW'($urandom), LW'($urandom), DW'($urandom));
         else frame(md, LW'($urandom), DW'($urandom), $urandom_range(1, 15), $urandom_range(1, 90));
      end

      // Reset while waiting for the opponent.
      frame(M_NORMAL, 20'h3C3C3, 32'h13572468, 4, 5);
      frame(M_NORMAL, 20'h4D4D4, 32'h24681357, 4, 5);
      start_frame();
      give_loc(20'h55555);
      wait_tx_start(20'h55555);
      pulse_tx_done(2);
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset");
      m_last = '0; m_good_run = 0; m_miss_run = 0; m_link = 1'b0; m_gtot = 0; m_mtot = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      d0 = dov_cnt;
      repeat (3) pulse_rx(DW'($urandom));
      repeat (5) tick();
      chk("idle after reset: no delivery", dov_cnt, d0);
      frame(M_TIMEOUT, 20'h66666, '0, 2, 0);
      frame(M_NORMAL, 20'h77777, 32'hFEEDF00D, 3, 20);
      repeat (3) tick();

      chk("scoreboard drained", sb.size(), 0);
`ifdef LINK_STATS_EN
      chk("good_count_out", lx.good_count_out, m_gtot);
      chk("miss_count_out", lx.miss_count_out, m_mtot);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
